// File: rtl/rns_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rns_pkg
// Description : Shared constants and types for the RNS forward-converter
//               residue channels. The modulus 21 is paired with a 6-bit
//               folding period because 2^6 mod 21 == 1. This lets a binary
//               operand be reduced by summing its 6-bit chunks.
// Contents    : DATA_W, MOD, PERIOD, NUM_CHUNKS, ACC_W, RES_W, CNT_W,
//               rns_seq_state_t
// Revision    : 1.0 - initial release
// ============================================================================
package rns_pkg;

   localparam int DATA_W     = 16;
   localparam int MOD        = 21;
   localparam int PERIOD     = 6;
   localparam int NUM_CHUNKS = (DATA_W + PERIOD - 1) / PERIOD;
   // The worst-case chunk sum is 63 + 63 + 15 = 141, so 8 bits are enough.
   localparam int ACC_W      = 8;
   localparam int RES_W      = 5;
   localparam int CNT_W      = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FOLD   = 2'd1,
      REDUCE = 2'd2,
      DONE   = 2'd3
   } rns_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/rns_mod_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : rns_mod_seq_if
// Description : Operand/result handshake bundle for the sequential residue
//               controller.
// Ports       : in_valid/in_ready/in_data   - operand channel
//               out_valid/out_ready/out_data - residue channel
//               busy                         - controller occupied
// Modports    : master (producer/consumer side), slave (controller side)
// Revision    : 1.0 - initial release
// ============================================================================
interface rns_mod_seq_if
   import rns_pkg::*;
#(
   parameter int WIDTH = DATA_W
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [RES_W-1:0] out_data;
   logic             busy;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, busy
   );

endinterface
`default_nettype wire

// File: rtl/rns_final_reduce.sv
`default_nettype none
// ============================================================================
// Module      : rns_final_reduce
// Description : Combinational final reduction of a folded accumulator to a
//               residue mod 21. The upper accumulator bits weigh 2^6 == 1,
//               so they fold straight onto the low chunk. That sum is at
//               most 66, and two conditional subtractions (2*MOD, then MOD)
//               bring it into 0..20.
// Ports       : acc     in  ACC_W  folded chunk sum
//               residue out RES_W  acc mod MOD
// Revision    : 1.0 - initial release
// ============================================================================
module rns_final_reduce
   import rns_pkg::*;
(
   input  logic [ACC_W-1:0] acc,
   output logic [RES_W-1:0] residue
);

   localparam int c_fold_w = PERIOD + 1;

   logic [c_fold_w-1:0] w_fold;
   logic [c_fold_w-1:0] w_sub2m;
   logic [c_fold_w-1:0] w_sub1m;

   always_comb begin
      w_fold  = c_fold_w'(acc[PERIOD-1:0]) + c_fold_w'(acc[ACC_W-1:PERIOD]);
      w_sub2m = (w_fold >= c_fold_w'(2 * MOD)) ? (w_fold - c_fold_w'(2 * MOD)) : w_fold;
      w_sub1m = (w_sub2m >= c_fold_w'(MOD)) ? (w_sub2m - c_fold_w'(MOD)) : w_sub2m;
      residue = RES_W'(w_sub1m);
   end

endmodule
`default_nettype wire

// File: rtl/rns_mod_seq.sv
`default_nettype none
// ============================================================================
// Module      : rns_mod_seq
// Description : Sequential N mod 21 controller. It accepts an operand in
//               IDLE and folds one 6-bit chunk per cycle into an
//               accumulator. It then reduces the sum in one cycle and holds
//               the residue in DONE until the consumer accepts it.
// Ports       : clk    in  rising-edge clock
//               rst_n  in  asynchronous active-low reset
//               bus    slave modport of rns_mod_seq_if (operand/result
//                      handshakes and busy)
// Config      : RNS_CHUNK_SKIP_EN - when defined, folding stops early once
//               the remaining shifted operand is zero
// Revision    : 1.0 - initial release
// ============================================================================
module rns_mod_seq
   import rns_pkg::*;
#(
   parameter int WIDTH = DATA_W
)(
   input  logic          clk,
   input  logic          rst_n,
   rns_mod_seq_if.slave  bus
);

   localparam int c_num_chunks = (WIDTH + PERIOD - 1) / PERIOD;
   localparam int c_cnt_w      = $clog2(c_num_chunks + 1);

   rns_seq_state_t     r_state;
   rns_seq_state_t     w_state_next;
   logic [WIDTH-1:0]   r_shift;
   logic [ACC_W-1:0]   r_acc;
   logic [c_cnt_w-1:0] r_count;
   logic [RES_W-1:0]   r_out_data;
   logic               r_out_valid;
   logic [RES_W-1:0]   w_residue;
   logic               w_last_fold;

   // The final chunk is narrower than PERIOD. The right shift fills it with
   // zeros, so it is zero-extended without extra logic.
`ifdef RNS_CHUNK_SKIP_EN
   assign w_last_fold = (r_count == c_cnt_w'(c_num_chunks - 1)) ||
                        (r_shift[WIDTH-1:PERIOD] == '0);
`else
   assign w_last_fold = (r_count == c_cnt_w'(c_num_chunks - 1));
`endif

   rns_final_reduce u_final_reduce (
      .acc     (r_acc),
      .residue (w_residue)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (bus.in_valid)  w_state_next = FOLD;
         FOLD:    if (w_last_fold)   w_state_next = REDUCE;
         REDUCE:                     w_state_next = DONE;
         DONE:    if (bus.out_ready) w_state_next = IDLE;
         default:                    w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift     <= '0;
         r_acc       <= '0;
         r_count     <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_shift <= bus.in_data;
                  r_acc   <= '0;
                  r_count <= '0;
               end
            end
            FOLD: begin
               r_acc   <= r_acc + ACC_W'(r_shift[PERIOD-1:0]);
               r_shift <= r_shift >> PERIOD;
               r_count <= r_count + c_cnt_w'(1);
            end
            REDUCE: begin
               r_out_data  <= w_residue;
               r_out_valid <= 1'b1;
            end
            DONE: begin
               // out_data is deliberately left holding the last result.
               if (bus.out_ready) r_out_valid <= 1'b0;
            end
            default: begin
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = (r_state == IDLE);
   assign bus.busy      = (r_state != IDLE);
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;

endmodule
`default_nettype wire
